// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator button controller:
// DDS tuning-word table, edit-field encodings and the update FSM states.
package fg_pkg;

  localparam int WAVE_W      = 2;
  localparam int IDX_W       = 4;
  localparam int FTW_ENTRIES = 10;

  // round(f * 2^32 / 24 MHz) for 100 Hz .. 100 kHz in a 1-2-5 sequence
  localparam logic [31:0] FTW_TABLE [0:FTW_ENTRIES-1] = '{
    32'd17896,   32'd35791,   32'd89478,   32'd178957,  32'd357914,
    32'd894785,  32'd1789570, 32'd3579139, 32'd8947849, 32'd17895697
  };

  localparam logic FIELD_WAVE = 1'b0;
  localparam logic FIELD_FREQ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_OFFER = 2'd2
  } fg_state_e;

endpackage

// File: rtl/fg_button_ctrl_if.sv
// Update channel from the button controller to the DDS core:
// offered waveform and tuning word with a valid/ready handshake.
interface fg_button_ctrl_if
  import fg_pkg::*;
#(
  parameter int FTW_W = 32
);
  logic [WAVE_W-1:0] Wave_sel;
  logic [FTW_W-1:0]  Ftw;
  logic              Upd_valid;
  logic              Upd_ready;

  modport master (output Wave_sel, output Ftw, output Upd_valid, input  Upd_ready);
  modport slave  (input  Wave_sel, input  Ftw, input  Upd_valid, output Upd_ready);
endinterface

// File: rtl/fg_ftw_rom.sv
// Combinational frequency-step to tuning-word lookup; out-of-range steps read 0.
module fg_ftw_rom
  import fg_pkg::*;
#(
  parameter int FTW_W = 32
) (
  input  logic [IDX_W-1:0] idx,
  output logic [FTW_W-1:0] ftw
);

  always_comb begin
    ftw = '0;
    if (idx < IDX_W'(FTW_ENTRIES)) begin
      ftw = FTW_W'(FTW_TABLE[idx]);
    end
  end

endmodule

// File: rtl/fg_button_ctrl.sv
// Turns debounced button pulses into waveform / frequency settings and
// delivers each changed setting to the DDS core over valid/ready.
module fg_button_ctrl
  import fg_pkg::*;
#(
  parameter int NUM_WAVES   = 4,
  parameter int NUM_STEPS   = 10,
  parameter int DEFAULT_IDX = 3,
  parameter int FTW_W       = 32
) (
  input  logic              Fg_clk,
  input  logic              Reset,
  input  logic              Btn_mode,
  input  logic              Btn_up,
  input  logic              Btn_down,
  output logic              Edit_field,
  output logic [IDX_W-1:0]  Freq_idx,
  fg_button_ctrl_if.master  upd
);

  logic [WAVE_W-1:0] wave_cur;
  logic [WAVE_W-1:0] wave_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              dirty;
  logic              edit_chg;
  logic              up_ev;
  logic              dn_ev;
  logic              load_en;
  logic [FTW_W-1:0]  rom_ftw;
  fg_state_e         state_q;
  fg_state_e         state_d;

  function automatic logic [WAVE_W-1:0] wrap_wave(input logic [WAVE_W-1:0] w,
                                                  input logic up);
    logic [WAVE_W-1:0] r;
    if (up) r = (w == WAVE_W'(NUM_WAVES - 1)) ? '0 : w + 1'b1;
    else    r = (w == '0) ? WAVE_W'(NUM_WAVES - 1) : w - 1'b1;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] sat_idx(input logic [IDX_W-1:0] i,
                                               input logic up);
    logic [IDX_W-1:0] r;
    if (up) r = (i == IDX_W'(NUM_STEPS - 1)) ? i : i + 1'b1;
    else    r = (i == '0) ? i : i - 1'b1;
    return r;
  endfunction

  // Simultaneous up and down cancel each other out
  assign up_ev = Btn_up & ~Btn_down;
  assign dn_ev = Btn_down & ~Btn_up;

  always_comb begin
    wave_nxt = wave_cur;
    idx_nxt  = Freq_idx;
    edit_chg = 1'b0;
    if (up_ev || dn_ev) begin
      if (Edit_field == FIELD_WAVE) begin
        wave_nxt = wrap_wave(wave_cur, up_ev);
        edit_chg = 1'b1;
      end else begin
        idx_nxt  = sat_idx(Freq_idx, up_ev);
        edit_chg = (idx_nxt != Freq_idx);
      end
    end
  end

  fg_ftw_rom #(.FTW_W(FTW_W)) u_rom (
    .idx (Freq_idx),
    .ftw (rom_ftw)
  );

  // IDLE also reacts to an edit in flight so LOAD lines up with the register update
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      ST_IDLE:  if (dirty || edit_chg) state_d = ST_LOAD;
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = ST_OFFER;
      end
      ST_OFFER: if (upd.Upd_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign upd.Upd_valid = (state_q == ST_OFFER);

  always_ff @(posedge Fg_clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      Edit_field   <= FIELD_WAVE;
      wave_cur     <= '0;
      Freq_idx     <= IDX_W'(DEFAULT_IDX);
      dirty        <= 1'b1;
      upd.Wave_sel <= '0;
      upd.Ftw      <= '0;
    end else begin
      state_q    <= state_d;
      Edit_field <= Edit_field ^ Btn_mode;
      wave_cur   <= wave_nxt;
      Freq_idx   <= idx_nxt;
      if (edit_chg)     dirty <= 1'b1;
      else if (load_en) dirty <= 1'b0;
      if (load_en) begin
        upd.Wave_sel <= wave_cur;
        upd.Ftw      <= rom_ftw;
      end
    end
  end

endmodule
